// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP slice B-operand input stage.
// Operand source encodings, flush FSM state type and counter width helper.
package dsp_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_DIRECT  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CASCADE = 2'b01;
  localparam logic [SEL_W-1:0] SEL_ZERO    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_RSVD    = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  // Flush counter must hold DEPTH-1; keep at least one bit so DEPTH=0/1 elaborate cleanly.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/b_input_stage_if.sv
// Operand/handshake bundle of the B input stage.
// master = slice control/source side, slave = the input stage itself.
interface b_input_stage_if #(
  parameter int WIDTH = 18
);
  import dsp_pkg::*;

  logic             ce;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] din_direct;
  logic [WIDTH-1:0] din_cascade;
  logic             in_valid;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic [WIDTH-1:0] bcout;
  logic             flushing;

  modport master (
    output ce, sel, din_direct, din_cascade, in_valid,
    input  dout, out_valid, bcout, flushing
  );

  modport slave (
    input  ce, sel, din_direct, din_cascade, in_valid,
    output dout, out_valid, bcout, flushing
  );

endinterface

// File: rtl/b_input_stage_pipe_stage.sv
// One B pipeline register: data plus valid bit, clock-enabled, with a
// synchronous valid-clear used to kill pre-switch operands on a mode change.
module bin_pipe_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic             vclr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o
);

  logic [WIDTH:0] stage_q;

  // Data still shifts on a clear; only the qualifier is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (ce_i) begin
      stage_q <= {v_i & ~vclr_i, d_i};
    end
  end

  assign q_o = stage_q[WIDTH-1:0];
  assign v_o = stage_q[WIDTH];

endmodule

// File: rtl/b_input_stage.sv
// B-operand input stage: source mux, DEPTH-stage clock-enabled pipeline and
// mode-switch flush tracking. Optional macro BIN_SEL_REG_EN registers sel first.
//
// state    | meaning
// ST_RUN   | flush_cnt==0, pipeline holds only current-mode operands
// ST_FLUSH | flush_cnt!=0, invalidated pre-switch stages still draining
module b_input_stage
  import dsp_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  b_input_stage_if.slave      bus
);

  logic [SEL_W-1:0] sel_eff;
  logic [WIDTH-1:0] mux_data;

`ifdef BIN_SEL_REG_EN
  logic [SEL_W-1:0] sel_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg_q <= SEL_DIRECT;
    end else if (bus.ce) begin
      sel_reg_q <= bus.sel;
    end
  end

  assign sel_eff = sel_reg_q;
`else
  assign sel_eff = bus.sel;
`endif

  // Reserved encoding behaves as ZERO.
  always_comb begin
    mux_data = '0;
    case (sel_eff)
      SEL_DIRECT:  mux_data = bus.din_direct;
      SEL_CASCADE: mux_data = bus.din_cascade;
      default:     mux_data = '0;
    endcase
  end

  generate
    if (DEPTH == 0) begin : g_comb
      assign bus.dout      = mux_data;
      assign bus.bcout     = mux_data;
      assign bus.out_valid = bus.in_valid;
      assign bus.flushing  = 1'b0;
    end else begin : g_pipe
      localparam int                CNT_W  = cnt_w(DEPTH);
      localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(DEPTH - 1);

      flush_state_e     state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [SEL_W-1:0] sel_q, sel_d;
      logic             sel_chg;

      logic [WIDTH-1:0] stg_data [DEPTH+1];
      logic             stg_vld  [DEPTH+1];

      assign stg_data[0] = mux_data;
      assign stg_vld[0]  = bus.in_valid;
      assign sel_chg     = (sel_eff != sel_q);

      for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        bin_pipe_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .ce_i   (bus.ce),
          .vclr_i ((k > 1) ? sel_chg : 1'b0),
          .d_i    (stg_data[k-1]),
          .v_i    (stg_vld[k-1]),
          .q_o    (stg_data[k]),
          .v_o    (stg_vld[k])
        );
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
          sel_q   <= SEL_DIRECT;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          sel_q   <= sel_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (bus.ce) begin
          sel_d = sel_eff;
          if (sel_chg) begin
            cnt_d = RELOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          state_d = (cnt_d != '0) ? ST_FLUSH : ST_RUN;
        end
      end

      always_comb begin
        bus.flushing  = (state_q == ST_FLUSH);
        bus.dout      = stg_data[DEPTH];
        bus.bcout     = stg_data[DEPTH];
        bus.out_valid = stg_vld[DEPTH];
      end
    end
  endgenerate

endmodule

// File: tb/tb_b_input_stage.sv
// Directed bench for b_input_stage: DEPTH=2 and DEPTH=3 instances driven in
// lockstep; expectations hand-computed, BIN_SEL_REG_EN shifts mode timing.
module tb_b_input_stage;
  import dsp_pkg::*;

`ifdef BIN_SEL_REG_EN
  localparam int SL = 1;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  b_input_stage_if #(.WIDTH(18)) if2 ();
  b_input_stage_if #(.WIDTH(18)) if3 ();

  b_input_stage #(.WIDTH(18), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  b_input_stage #(.WIDTH(18), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic [1:0] sel, input logic [17:0] dd,
                       input logic [17:0] dc, input logic iv);
    if2.ce = ce; if2.sel = sel; if2.din_direct = dd; if2.din_cascade = dc; if2.in_valid = iv;
    if3.ce = ce; if3.sel = sel; if3.din_direct = dd; if3.din_cascade = dc; if3.in_valid = iv;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive(1'b1, SEL_DIRECT, 18'h0, 18'h0, 1'b0);
    tick(2);
    chk("rst_dout",     32'(if2.dout), 32'h0);
    chk("rst_bcout",    32'(if2.bcout), 32'h0);
    chk("rst_ovalid",   32'(if2.out_valid), 32'h0);
    chk("rst_flushing", 32'(if2.flushing), 32'h0);
    rst_n = 1'b1;

    // latency: DEPTH=2
    drive(1'b1, SEL_DIRECT, 18'h1234, 18'h0, 1'b1);
    tick(1);
    chk("lat_e0_ovalid", 32'(if2.out_valid), 32'h0);
    drive(1'b1, SEL_DIRECT, 18'h0BEE, 18'h0, 1'b0);
    tick(1);
    chk("lat_e1_dout",   32'(if2.dout), 32'h1234);
    chk("lat_e1_ovalid", 32'(if2.out_valid), 32'h1);
    tick(1);
    chk("lat_bubble_ovalid", 32'(if2.out_valid), 32'h0);

    // mode select
    drive(1'b1, SEL_CASCADE, 18'h0BEE, 18'h3FFFF, 1'b1);
    tick(3);
    chk("cas_dout",     32'(if2.dout), 32'h3FFFF);
    chk("cas_bcout",    32'(if2.bcout), 32'h3FFFF);
    chk("cas_ovalid",   32'(if2.out_valid), 32'h1);
    chk("cas_flushing", 32'(if2.flushing), 32'h0);
    drive(1'b1, SEL_RSVD, 18'h0BEE, 18'h3FFFF, 1'b1);
    tick(3);
    chk("rsvd_dout",   32'(if2.dout), 32'h0);
    chk("rsvd_ovalid", 32'(if2.out_valid), 32'h1);

    // clock enable freeze
    drive(1'b1, SEL_DIRECT, 18'h1111, 18'h0, 1'b1);
    tick(3);
    chk("ce_pre_dout", 32'(if2.dout), 32'h1111);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, SEL_DIRECT, 18'(18'h2222 + i), 18'h0, 1'b0);
      tick(1);
      chk("ce_hold_dout",   32'(if2.dout), 32'h1111);
      chk("ce_hold_ovalid", 32'(if2.out_valid), 32'h1);
    end
    drive(1'b1, SEL_DIRECT, 18'h5555, 18'h0, 1'b1);
    tick(1);
    chk("ce_resume1_dout", 32'(if2.dout), 32'h1111);
    tick(1);
    chk("ce_resume2_dout", 32'(if2.dout), 32'h5555);

    // asynchronous reset mid-flush
    drive(1'b1, SEL_CASCADE, 18'h5555, 18'h2AAAA, 1'b1);
    tick(1 + SL);
    chk("prerst_flushing", 32'(if3.flushing), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_dout",      32'(if2.dout), 32'h0);
    chk("arst_ovalid",    32'(if2.out_valid), 32'h0);
    chk("arst_flushing2", 32'(if2.flushing), 32'h0);
    chk("arst_flushing3", 32'(if3.flushing), 32'h0);
    tick(2);
    rst_n = 1'b1;

    // mode switch with DEPTH=3
    drive(1'b1, SEL_DIRECT, 18'h0AAAA, 18'h03C3C, 1'b1);
    tick(4);
    chk("sw_pre_dout",     32'(if3.dout), 32'h0AAAA);
    chk("sw_pre_flushing", 32'(if3.flushing), 32'h0);
    drive(1'b1, SEL_CASCADE, 18'h0AAAA, 18'h03C3C, 1'b1);
    if (SL != 0) begin
      tick(1);
      chk("sw_selreg_flushing", 32'(if3.flushing), 32'h0);
    end
    tick(1);
    chk("sw_e1_flushing", 32'(if3.flushing), 32'h1);
    chk("sw_e1_ovalid",   32'(if3.out_valid), 32'h0);
    tick(1);
    chk("sw_e2_flushing", 32'(if3.flushing), 32'h1);
    chk("sw_e2_ovalid",   32'(if3.out_valid), 32'h0);
    tick(1);
    chk("sw_e3_flushing", 32'(if3.flushing), 32'h0);
    chk("sw_e3_ovalid",   32'(if3.out_valid), 32'h1);
    chk("sw_e3_dout",     32'(if3.dout), 32'h03C3C);

    // reload mid-flush: 01 -> 10 then 10 -> 01
    drive(1'b1, SEL_ZERO, 18'h0AAAA, 18'h03C3C, 1'b1);
    tick(1 + SL);
    chk("rl_a_flushing", 32'(if3.flushing), 32'h1);
    drive(1'b1, SEL_CASCADE, 18'h0AAAA, 18'h03C3C, 1'b1);
    tick(1 + SL);
    chk("rl_b_flushing", 32'(if3.flushing), 32'h1);
    chk("rl_b_ovalid",   32'(if3.out_valid), 32'h0);
    tick(1);
    chk("rl_c_flushing", 32'(if3.flushing), 32'h1);
    chk("rl_c_ovalid",   32'(if3.out_valid), 32'h0);
    tick(1);
    chk("rl_d_flushing", 32'(if3.flushing), 32'h0);
    chk("rl_d_ovalid",   32'(if3.out_valid), 32'h1);
    chk("rl_d_dout",     32'(if3.dout), 32'h03C3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/b_input_stage.md
Name: b_input_stage

Overview:
Parametrised B-operand input stage for the DSP slice. It selects the operand from the direct port, the cascade port or a forced zero. It then carries the selected operand through a configurable clock-enabled register pipeline with a valid bit per stage. It drives both the multiplier/pre-adder B path and the cascade output to the next slice. When the mode select changes, operands already in flight are invalidated so downstream never combines old-mode data with new-mode configuration.

Parameters:
WIDTH, 18, operand width in bits; legal 1..48.
DEPTH, 1, number of B pipeline register stages; legal 0..4; 0 = purely combinational path.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
ce  input  1  clock enable for all pipeline, select-tracking and flush state.
sel  input  2  operand source: 00 DIRECT, 01 CASCADE, 10 ZERO, 11 reserved (treated as ZERO).
din_direct  input  WIDTH  direct B operand.
din_cascade  input  WIDTH  B operand from the previous slice's bcout.
in_valid  input  1  qualifies the selected operand this cycle.
dout  output  WIDTH  pipelined B operand to the arithmetic path.
out_valid  output  1  dout qualifier.
bcout  output  WIDTH  cascade output to the next slice; always equal to dout.
flushing  output  1  high while the pipeline still holds invalidated pre-switch stages.

Behaviour:
- Mux (combinational): sel=00 selects din_direct; 01 selects din_cascade; 10 or 11 selects all-zeros. The operand is qualified by in_valid in every mode (zero is valid data).
- DEPTH=0:
  - dout = mux output; out_valid = in_valid.
  - flushing is tied 0; no sel tracking.
- DEPTH>=1, pipeline:
  - Stages s1..sDEPTH, each holding data and a valid bit.
  - On a rising edge with ce=1: s1 <= {mux, in_valid}; sk <= s(k-1).
  - With ce=0, all state holds.
  - dout/out_valid come from sDEPTH. Latency = DEPTH ce-qualified edges.
- Select tracking:
  - sel_q holds the last accepted sel; reset value 00.
  - On a ce=1 edge with sel != sel_q (all 2 bits compared; 10 vs 11 counts as a change):
    - sel_q <= sel.
    - s1 captures the new operand normally.
    - Valid bits of s2..sDEPTH are cleared. Their data shifts as usual; data is not zeroed.
    - flush_cnt <= DEPTH-1.
  - sel changes while ce=0 have no effect until the next ce=1 edge.
- Flush state machine:
  - RUN: flush_cnt==0.
  - FLUSH: flush_cnt!=0; flushing=1 in this state.
  - flush_cnt decrements on each ce=1 edge without a new sel change.
  - A sel change during FLUSH reloads flush_cnt to DEPTH-1 and re-clears valids.
  - DEPTH=1 never enters FLUSH.
- Reset (asynchronous, takes effect immediately, including mid-flush):
  - All stage data 0, all valid 0, sel_q=00, flush_cnt=0.
  - dout=0, bcout=0, out_valid=0, flushing=0.
- Widths: no arithmetic; flush_cnt is clog2(DEPTH+1) bits, minimum 1.

Optional Feature:
BIN_SEL_REG_EN:
- Defined: sel passes through one ce-qualified register (reset 00) before the mux and change detection. A mode switch therefore takes effect one ce edge later; data latency is unchanged.
- Undefined: sel is used directly, as described above.

Decomposition:
- dsp_pkg: SEL_DIRECT=2'b00, SEL_CASCADE=2'b01, SEL_ZERO=2'b10, SEL_RSVD=2'b11; sel width constant SEL_W=2.
- One natural sub-module: bin_pipe_stage. It is a single WIDTH+1-bit register with async active-low reset, ce, and a synchronous valid-clear input. It is instantiated DEPTH times via generate.

Test Plan:
- Reset: assert rst_n=0 mid-stream with DEPTH=2 -> dout=0, out_valid=0, flushing=0 immediately, without waiting for a clock edge.
- Latency: WIDTH=18, DEPTH=2, sel=00, ce=1; din_direct=0x1234 with in_valid=1 at edge 0 -> dout=0x1234, out_valid=1 after edge 1.
- Mode select: sel=01, din_cascade=0x3FFFF -> dout=0x3FFFF; sel=11 -> dout=0x00000 with out_valid=1.
- Clock enable: ce=0 for 3 cycles while din_direct changes -> dout and out_valid frozen; ce=1 resumes shifting.
- Mode switch, DEPTH=3, continuous valid input:
  - sel 00->01 -> next cycle s2/s3 invalid, out_valid=0 and flushing=1 for 2 ce edges.
  - Then out_valid=1 with cascade data, flushing=0.
  - A second sel change mid-flush -> counter reloads to 2.
- BIN_SEL_REG_EN defined: same switch -> flushing rises one ce edge later than without the macro; data latency still DEPTH.
